// File: rtl/stream_mux_arb_if.sv
// Stream bundle between N_CH input channels and one output of stream_mux_arb.
// slave is the mux side; master is the side that drives the sources and the sink.
`ifndef DATA_BUS_LEN
`define DATA_BUS_LEN 8
`endif

interface stream_mux_arb_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = `DATA_BUS_LEN
);
  localparam int SEL_W = $clog2(N_CH);

  logic [1:0]             MODE;
  logic [SEL_W-1:0]       SEL;
  logic [N_CH*DATA_W-1:0] IN_DATA;
  logic [N_CH-1:0]        IN_VALID;
  logic [N_CH-1:0]        IN_LAST;
  logic [N_CH-1:0]        IN_READY;
  logic [DATA_W-1:0]      OUT_DATA;
  logic                   OUT_VALID;
  logic                   OUT_LAST;
  logic [SEL_W-1:0]       OUT_CH;
  logic                   OUT_READY;
  logic                   BUSY;

  modport slave (
    input  MODE, SEL, IN_DATA, IN_VALID, IN_LAST, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID, OUT_LAST, OUT_CH, BUSY
  );

  modport master (
    output MODE, SEL, IN_DATA, IN_VALID, IN_LAST, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID, OUT_LAST, OUT_CH, BUSY
  );
endinterface

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with static, round-robin or fixed-priority
// selection, a registered output stage and packet locking until LAST.
`ifndef DATA_BUS_LEN
`define DATA_BUS_LEN 8
`endif

module stream_mux_arb #(
  parameter int N_CH   = 4,
  parameter int DATA_W = `DATA_BUS_LEN
) (
  input logic             CLK,
  input logic             RST_N,
  stream_mux_arb_if.slave bus
);
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic [DATA_W-1:0] ch_data [N_CH];
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_last;
  logic              load_en;
  logic              xfer;
  int                scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi]     = bus.IN_DATA[gi*DATA_W +: DATA_W];
      assign bus.IN_READY[gi] = xfer && (gnt_idx == SEL_W'(gi));
    end
  endgenerate

  // Scans run high-to-low so the last hit (the preferred channel) wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    if (state_q == LOCKED) begin
      for (int i = 0; i < N_CH; i++) begin
        if (lock_ch_q == SEL_W'(i) && bus.IN_VALID[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      case (bus.MODE)
        2'b00: begin
          for (int i = 0; i < N_CH; i++) begin
            if (bus.SEL == SEL_W'(i) && bus.IN_VALID[i]) begin
              gnt_vld = 1'b1;
              gnt_idx = SEL_W'(i);
            end
          end
        end
        2'b01: begin
          for (int k = N_CH - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= N_CH) scan_idx = scan_idx - N_CH;
            if (bus.IN_VALID[scan_idx]) begin
              gnt_vld = 1'b1;
              gnt_idx = SEL_W'(scan_idx);
            end
          end
        end
        default: begin
          for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.IN_VALID[i]) begin
              gnt_vld = 1'b1;
              gnt_idx = SEL_W'(i);
            end
          end
        end
      endcase
    end
  end

  assign load_en  = !out_valid_q || bus.OUT_READY;
  assign xfer     = gnt_vld && load_en;
  assign gnt_last = bus.IN_LAST[gnt_idx];

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_data_d  = ch_data[gnt_idx];
      out_last_d  = gnt_last;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (state_q == IDLE && !gnt_last) begin
        state_d   = LOCKED;
        lock_ch_d = gnt_idx;
      end else if (state_q == LOCKED && gnt_last) begin
        state_d = IDLE;
      end
      if (bus.MODE == 2'b01 && gnt_last) begin
        rr_ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
    end else if (bus.OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_LAST  = out_last_q;
  assign bus.OUT_CH    = out_ch_q;
  assign bus.BUSY      = (state_q == LOCKED);
endmodule

// File: tb/tb_stream_mux_arb.sv
// Randomized scoreboard bench for stream_mux_arb: a packet-level reference model
// predicts grants and pushes expected beats; a monitor checks every output beat.
module tb_stream_mux_arb;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  stream_mux_arb_if #(.N_CH(4), .DATA_W(8)) ifc ();
  stream_mux_arb_if #(.N_CH(3), .DATA_W(8)) ifc3 ();

  stream_mux_arb #(.N_CH(4), .DATA_W(8)) dut (.CLK(CLK), .RST_N(RST_N), .bus(ifc));
  stream_mux_arb #(.N_CH(3), .DATA_W(8)) dut3 (.CLK(CLK), .RST_N(RST_N), .bus(ifc3));

  typedef struct {logic [7:0] d; logic l;} beat_t;
  typedef struct {logic [7:0] d; logic l; int ch;} exp_t;

  beat_t src_q[4][$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;

  // model state: output buffer occupancy, packet lock, round-robin pointer
  bit m_full, m_locked;
  int m_lock_ch, m_rr;

  // driver knobs
  bit drv_on = 0;
  bit sel_rand = 0;
  int vpct = 100, rpct = 100, stall_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      if (drv_on && src_q[c].size() > 0 && $urandom_range(99) < vpct) begin
        ifc.IN_VALID[c]       = 1'b1;
        ifc.IN_DATA[c*8 +: 8] = src_q[c][0].d;
        ifc.IN_LAST[c]        = src_q[c][0].l;
      end else begin
        ifc.IN_VALID[c] = 1'b0;
      end
    end
    if (!drv_on || rpct >= 100) ifc.OUT_READY = 1'b1;
    else if (stall_cnt > 0) begin
      ifc.OUT_READY = 1'b0;
      stall_cnt--;
    end else if ($urandom_range(99) < 4) begin
      ifc.OUT_READY = 1'b0;
      stall_cnt = 4;
    end else ifc.OUT_READY = ($urandom_range(99) < rpct);
    if (drv_on && sel_rand && $urandom_range(9) == 0) ifc.SEL = 2'($urandom_range(3));
  endtask

  task automatic do_reset(input bit at_edge);
    if (at_edge) begin
      @(posedge CLK);
      #2;
    end
    RST_N = 1'b0;
    drv_on = 0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) src_q[c].delete();
    ifc.IN_VALID = '0;
    ifc.OUT_READY = 1'b1;
    #1;
    chk("rst_out_valid", 32'(ifc.OUT_VALID), 0);
    chk("rst_busy", 32'(ifc.BUSY), 0);
    chk("rst_out_data", 32'(ifc.OUT_DATA), 0);
    chk("rst_out_last", 32'(ifc.OUT_LAST), 0);
    chk("rst_out_ch", 32'(ifc.OUT_CH), 0);
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  task automatic fill(input int maxlen);
    int len;
    beat_t b;
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 30; p++) begin
        len = $urandom_range(maxlen, 1);
        for (int k = 0; k < len; k++) begin
          b.d = 8'($urandom);
          b.l = (k == len - 1);
          src_q[c].push_back(b);
        end
      end
    end
  endtask

  task automatic run_phase(input int mode, input int maxlen, input int vp, input int rp,
                           input int cycles, input bit srand);
    do_reset(1);
    ifc.MODE = 2'(mode);
    ifc.SEL = 2'($urandom_range(3));
    sel_rand = srand;
    vpct = vp;
    rpct = rp;
    stall_cnt = 0;
    fill(maxlen);
    drv_on = 1;
    repeat (cycles) begin
      @(posedge CLK);
      #1;
      drive();
    end
    drv_on = 0;
    repeat (4) begin
      @(posedge CLK);
      #1;
      drive();
    end
    @(negedge CLK);
    #2;
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  // reference model: grant rules applied to a one-entry output buffer
  initial begin
    int cand, c;
    logic [3:0] exp_rdy;
    beat_t b;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        m_full = 0;
        m_locked = 0;
        m_lock_ch = 0;
        m_rr = 0;
      end else begin
        cand = -1;
        if (m_locked) begin
          if (ifc.IN_VALID[m_lock_ch]) cand = m_lock_ch;
        end else if (ifc.MODE == 2'b00) begin
          if (ifc.IN_VALID[ifc.SEL]) cand = int'(ifc.SEL);
        end else if (ifc.MODE == 2'b01) begin
          for (int k = 0; k < 4; k++) begin
            c = (m_rr + k) % 4;
            if (ifc.IN_VALID[c]) begin
              cand = c;
              break;
            end
          end
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (ifc.IN_VALID[k]) begin
              cand = k;
              break;
            end
          end
        end
        exp_rdy = ((!m_full || ifc.OUT_READY) && cand >= 0) ? (4'b0001 << cand) : 4'b0000;
        chk("in_ready", 32'(ifc.IN_READY), 32'(exp_rdy));
        chk("busy", 32'(ifc.BUSY), 32'(m_locked));
        if (exp_rdy != 0) begin
          b = src_q[cand].pop_front();
          e.d = b.d;
          e.l = b.l;
          e.ch = cand;
          exp_q.push_back(e);
          if (!m_locked && !b.l) begin
            m_locked = 1;
            m_lock_ch = cand;
          end else if (m_locked && b.l) m_locked = 0;
          if (ifc.MODE == 2'b01 && b.l) m_rr = (cand + 1) % 4;
          m_full = 1;
        end else if (ifc.OUT_READY) m_full = 0;
      end
    end
  end

  // monitor: every presented beat must match the oldest expected beat
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (RST_N && ifc.OUT_VALID) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got beat ch=%0d data=%h expected none", ifc.OUT_CH, ifc.OUT_DATA);
        end else begin
          e = exp_q[0];
          chk("out_data", 32'(ifc.OUT_DATA), 32'(e.d));
          chk("out_last", 32'(ifc.OUT_LAST), 32'(e.l));
          chk("out_ch", 32'(ifc.OUT_CH), 32'(e.ch));
          if (ifc.OUT_READY) begin
            void'(exp_q.pop_front());
            $display("beat ch=%0d data=%h last=%0d", ifc.OUT_CH, ifc.OUT_DATA, ifc.OUT_LAST);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    ifc.MODE = 2'b00;
    ifc.SEL = '0;
    ifc.IN_DATA = '0;
    ifc.IN_VALID = '0;
    ifc.IN_LAST = '0;
    ifc.OUT_READY = 1'b1;
    ifc3.MODE = 2'b00;
    ifc3.SEL = 2'd3;
    ifc3.IN_DATA = 24'hC2C1C0;
    ifc3.IN_VALID = 3'b111;
    ifc3.IN_LAST = 3'b111;
    ifc3.OUT_READY = 1'b1;

    do_reset(0);
    repeat (5) begin
      @(negedge CLK);
      #1;
      chk("n3_sel_oob_ready", 32'(ifc3.IN_READY), 0);
      chk("n3_sel_oob_valid", 32'(ifc3.OUT_VALID), 0);
    end

    run_phase(0, 3, 80, 80, 300, 1);
    run_phase(1, 1, 100, 100, 100, 0);
    run_phase(1, 4, 70, 70, 300, 0);
    run_phase(2, 4, 70, 60, 300, 0);
    run_phase(3, 3, 90, 90, 200, 0);

    // reset while a packet is locked, then confirm arbitration restarts cleanly
    do_reset(1);
    ifc.MODE = 2'b01;
    vpct = 90;
    rpct = 90;
    stall_cnt = 0;
    sel_rand = 0;
    fill(4);
    drv_on = 1;
    for (int t = 0; t < 200 && !m_locked; t++) begin
      @(posedge CLK);
      #1;
      drive();
    end
    chk("busy_before_rst", 32'(ifc.BUSY), 1);
    do_reset(0);
    run_phase(1, 2, 80, 80, 150, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
